// File: rtl/rotor_stepper.sv
// Three-rotor odometer stepper: advances rotor offsets on each accepted key and emits a registered encipher request.
// Optional macro ROTOR_STEPPER_DOUBLE_STEP_EN selects historic double-stepping of the middle rotor.
module rotor_stepper #(
  parameter int unsigned NOTCH1 = 16,
  parameter int unsigned NOTCH2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [4:0] key_in,
  input  logic       load,
  input  logic [4:0] load_pos1,
  input  logic [4:0] load_pos2,
  input  logic [4:0] load_pos3,
  output logic [4:0] rot1,
  output logic [4:0] rot2,
  output logic [4:0] rot3,
  output logic [4:0] key_out,
  output logic       out_valid
);

  localparam logic [4:0] N1 = NOTCH1[4:0];
  localparam logic [4:0] N2 = NOTCH2[4:0];

  logic [4:0] rot1_q, rot1_d;
  logic [4:0] rot2_q, rot2_d;
  logic [4:0] rot3_q, rot3_d;
  logic [4:0] key_q, key_d;
  logic       valid_q, valid_d;
  logic       accept;
  logic       step2;
  logic       step3;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] v);
    return (v >= 5'd26) ? 5'd0 : v;
  endfunction

  // Handshake: no backpressure. A key is taken whenever key_valid is high with a legal
  // letter code and no load; out_valid pulses exactly one cycle later for that key only.
  assign accept = key_valid && (key_in >= 5'd1) && (key_in <= 5'd26) && !load;

  // Notch tests use pre-step values so all three rotors update together.
`ifdef ROTOR_STEPPER_DOUBLE_STEP_EN
  assign step2 = (rot1_q == N1) || (rot2_q == N2);
  assign step3 = (rot2_q == N2);
`else
  assign step2 = (rot1_q == N1);
  assign step3 = step2 && (rot2_q == N2);
`endif

  always_comb begin
    rot1_d  = rot1_q;
    rot2_d  = rot2_q;
    rot3_d  = rot3_q;
    key_d   = key_q;
    valid_d = 1'b0;
    if (load) begin
      rot1_d = clamp26(load_pos1);
      rot2_d = clamp26(load_pos2);
      rot3_d = clamp26(load_pos3);
    end else if (accept) begin
      rot1_d  = inc26(rot1_q);
      rot2_d  = step2 ? inc26(rot2_q) : rot2_q;
      rot3_d  = step3 ? inc26(rot3_q) : rot3_q;
      key_d   = key_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rot1_q  <= 5'd0;
      rot2_q  <= 5'd0;
      rot3_q  <= 5'd0;
      key_q   <= 5'd0;
      valid_q <= 1'b0;
    end else begin
      rot1_q  <= rot1_d;
      rot2_q  <= rot2_d;
      rot3_q  <= rot3_d;
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  assign rot1      = rot1_q;
  assign rot2      = rot2_q;
  assign rot3      = rot3_q;
  assign key_out   = key_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper: directed vectors, expected-response queue drained by a monitor.
module tb_rotor_stepper;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [4:0] key_in;
  logic       load;
  logic [4:0] load_pos1, load_pos2, load_pos3;
  logic [4:0] rot1, rot2, rot3, key_out;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  // Entry layout: {key_out, rot1, rot2, rot3}
  logic [19:0] exp_q[$];
  logic [19:0] mon_exp;
  logic [19:0] mon_act;

`ifdef ROTOR_STEPPER_DOUBLE_STEP_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  rotor_stepper #(.NOTCH1(16), .NOTCH2(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_in    (key_in),
    .load      (load),
    .load_pos1 (load_pos1),
    .load_pos2 (load_pos2),
    .load_pos3 (load_pos3),
    .rot1      (rot1),
    .rot2      (rot2),
    .rot3      (rot3),
    .key_out   (key_out),
    .out_valid (out_valid)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Monitor: every out_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      mon_act = {key_out, rot1, rot2, rot3};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got key_out=%0d rot=%0d,%0d,%0d, required no out_valid",
                 key_out, rot1, rot2, rot3);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL pulse_data: got key_out=%0d rot=%0d,%0d,%0d, required key_out=%0d rot=%0d,%0d,%0d",
                   mon_act[19:15], mon_act[14:10], mon_act[9:5], mon_act[4:0],
                   mon_exp[19:15], mon_exp[14:10], mon_exp[9:5], mon_exp[4:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic cycle(input logic rs, input logic kv, input logic [4:0] k, input logic ld,
                       input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3);
    reset     = rs;
    key_valid = kv;
    key_in    = k;
    load      = ld;
    load_pos1 = p1;
    load_pos2 = p2;
    load_pos3 = p3;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_load(input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3);
    cycle(1'b0, 1'b0, 5'd0, 1'b1, p1, p2, p3);
  endtask

  task automatic send_key(input logic [4:0] k, input logic [4:0] e1, input logic [4:0] e2,
                          input logic [4:0] e3);
    exp_q.push_back({k, e1, e2, e3});
    cycle(1'b0, 1'b1, k, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic check_state(input string name, input logic [4:0] e1, input logic [4:0] e2,
                             input logic [4:0] e3, input logic [4:0] ek, input logic ev);
    checks++;
    if ({rot1, rot2, rot3, key_out, out_valid} !== {e1, e2, e3, ek, ev}) begin
      errors++;
      $display("FAIL %s: got rot=%0d,%0d,%0d key_out=%0d out_valid=%0b, required rot=%0d,%0d,%0d key_out=%0d out_valid=%0b",
               name, rot1, rot2, rot3, key_out, out_valid, e1, e2, e3, ek, ev);
    end
  endtask

  initial begin
    // Reset held two cycles with a legal key presented
    cycle(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0, 5'd0);
    check_state("reset_hold_1", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0, 5'd0);
    check_state("reset_hold_2", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle();
    check_state("idle_after_reset", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);

    // 26 back-to-back keys: rot1 wraps, rot2 steps on the 17th key
    for (int i = 1; i <= 26; i++) begin
      send_key(5'd1, 5'(i % 26), (i >= 17) ? 5'd1 : 5'd0, 5'd0);
    end
    idle();
    check_state("hold_after_run", 5'd0, 5'd1, 5'd0, 5'd1, 1'b0);

    // Both notches hit at once
    do_load(5'd16, 5'd4, 5'd7);
    check_state("load_16_4_7", 5'd16, 5'd4, 5'd7, 5'd1, 1'b0);
    send_key(5'd5, 5'd17, 5'd5, 5'd8);
    idle();
    check_state("hold_after_double_notch", 5'd17, 5'd5, 5'd8, 5'd5, 1'b0);

    // Middle rotor sitting on its notch without rotor-1 carry
    do_load(5'd0, 5'd4, 5'd0);
    check_state("load_0_4_0", 5'd0, 5'd4, 5'd0, 5'd5, 1'b0);
    send_key(5'd1, 5'd1, DS ? 5'd5 : 5'd4, DS ? 5'd1 : 5'd0);

    // Load wins over a simultaneous key; out-of-range position loads as 0
    cycle(1'b0, 1'b1, 5'd9, 1'b1, 5'd30, 5'd3, 5'd25);
    check_state("load_priority", 5'd0, 5'd3, 5'd25, 5'd1, 1'b0);
    idle();
    check_state("load_no_late_pulse", 5'd0, 5'd3, 5'd25, 5'd1, 1'b0);

    // Illegal codes and key_valid low are ignored
    cycle(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_state("key_zero", 5'd0, 5'd3, 5'd25, 5'd1, 1'b0);
    cycle(1'b0, 1'b1, 5'd27, 1'b0, 5'd0, 5'd0, 5'd0);
    check_state("key_27", 5'd0, 5'd3, 5'd25, 5'd1, 1'b0);
    cycle(1'b0, 1'b1, 5'd31, 1'b0, 5'd0, 5'd0, 5'd0);
    check_state("key_31", 5'd0, 5'd3, 5'd25, 5'd1, 1'b0);
    cycle(1'b0, 1'b0, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0);
    check_state("key_valid_low", 5'd0, 5'd3, 5'd25, 5'd1, 1'b0);

    // Highest legal code
    send_key(5'd26, 5'd1, 5'd3, 5'd25);

    // rot2 wrap 25 -> 0 without stepping rot3
    do_load(5'd16, 5'd25, 5'd3);
    check_state("load_16_25_3", 5'd16, 5'd25, 5'd3, 5'd26, 1'b0);
    send_key(5'd7, 5'd17, 5'd0, 5'd3);

    // rot3 wrap 25 -> 0
    do_load(5'd16, 5'd4, 5'd25);
    check_state("load_16_4_25", 5'd16, 5'd4, 5'd25, 5'd7, 1'b0);
    send_key(5'd2, 5'd17, 5'd5, 5'd0);

    // Back-to-back keys, then reset (with load and key) right after acceptance
    send_key(5'd3, 5'd18, 5'd5, 5'd0);
    send_key(5'd4, 5'd19, 5'd5, 5'd0);
    cycle(1'b1, 1'b1, 5'd8, 1'b1, 5'd5, 5'd5, 5'd5);
    check_state("reset_priority", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle();
    check_state("idle_after_reset_2", 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle();

    // Every expected pulse must have been seen
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
